bin2bcd_converter: RTL and testbench
====================================

// Module: bin2bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the Fibonacci
//  display path. Sits directly downstream of the Fibonacci FSMD and takes its 16-bit result.
//  Produces 4 packed BCD digits for the seven-segment multiplexer.
//  Uses the same start / ready / done_tick handshake as the other FSMDs in the design.
// PARAMETERS
//  BIN_W   16  width of the binary input; also the number of shift iterations
//  DIGITS  4   number of BCD digits produced (the max representable value is 10^DIGITS-1)
// PORTS
//  i_clk        in   1           clock; all logic works on its rising edge
//  i_rst        in   1           synchronous, active-high reset
//  i_start      in   1           start request; sampled only in e_idle
//  i_bin        in   BIN_W       unsigned binary operand; sampled only with an accepted i_start
//  o_ready      out  1           high while in e_idle (ready to accept i_start)
//  o_done_tick  out  1           one-cycle pulse in e_done
//  o_bcd        out  4*DIGITS    packed BCD, [3:0] = ones; registered, held until the next start
//  o_overflow   out  1           operand exceeded 10^DIGITS-1; only meaningful with the macro
// BEHAVIOUR
//  - Reset: state e_idle, digit and shift registers 0, iteration counter 0.
//    After reset: o_bcd = 0, o_overflow = 0, o_done_tick = 0, o_ready = 1.
//    Reset has priority over all other inputs.
//    Reset during e_op or e_done aborts the conversion; no done_tick is issued.
//  - States: e_idle -> e_op -> e_done -> e_idle (enum is 2 bits; the unused encoding goes to e_idle).
//  - e_idle
//    - On i_start: load the shift register with i_bin, clear the digit registers,
//      set the counter to BIN_W, go to e_op.
//    - o_bcd keeps its previous result until this load.
//  - e_op, one iteration per cycle:
//    - Each digit d >= 5 gets d+3. The adjusted digits then shift left 1; the shift-register MSB
//      enters the ones LSB.
//    - The counter decrements; at counter == 1 the last shift happens and the next state is e_done.
//  - e_done: o_done_tick = 1 for exactly one cycle, then e_idle. o_bcd is valid in this cycle.
//  - Latency: with i_start sampled at edge k, o_done_tick is high in the cycle after edge
//    k+BIN_W (BIN_W+1 cycles). The next start can be accepted one cycle later.
//  - i_start outside e_idle is ignored; there is no queueing. i_bin changes outside acceptance
//    have no effect.
//  - Digit carry out of the most-significant digit is discarded, so without clamping the
//    result is i_bin mod 10^DIGITS.
//  - Operand 0: o_bcd = 0 after the full BIN_W iterations (no early exit, fixed latency).
// CONFIGURATION
//  - Macro BIN2BCD_CLAMP_EN.
//  - Defined: on accept, i_bin > 10^DIGITS-1 skips e_op.
//    - Digits load all-9s and o_overflow is registered 1; the state goes straight to e_done.
//    - done_tick comes 1 cycle after accept.
//    - o_overflow is held with o_bcd and cleared on the next accepted start.
//  - Undefined: no compare logic; o_overflow is tied 0 and the result wraps modulo 10^DIGITS.
// STRUCTURE
//  - Package bin2bcd_pkg holds:
//    - typedef enum logic [1:0] {e_idle, e_op, e_done} t_bcd_state
//    - function bcd_max(DIGITS) returning 10^DIGITS-1
//  - Sub-module bcd_digit_adj: purely combinational 4-bit "add 3 if >= 5".
//    One instance per digit, via generate.
//  - Everything else (registers, counter, FSM) lives in the top module.
// TESTING
//  1. i_bin=0, i_start pulse -> done_tick after 17 cycles, o_bcd=16'h0000, o_overflow=0.
//  2. i_bin=6765 -> o_bcd=16'h6765; o_ready low for exactly 17 cycles after accept.
//  3. i_bin=9999 -> o_bcd=16'h9999, o_overflow=0. i_bin=1 -> 16'h0001.
//  4. i_bin=10946, clamp defined -> o_bcd=16'h9999, o_overflow=1, done 1 cycle after accept.
//     Clamp undefined -> o_bcd=16'h0946, o_overflow=0, 17 cycles.
//  5. i_start re-pulsed with i_bin=1234 during conversion of 4321
//     -> ignored; result 16'h4321, single done_tick.
//  6. i_rst asserted 5 cycles into a conversion -> no done_tick, o_bcd=0, o_ready=1 next cycle.
//     A later conversion of 55 -> 16'h0055.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// bcd_max() gives the largest value representable in a given number of BCD digits.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_op,
        e_done
    } t_bcd_state;

    function automatic logic [63:0] bcd_max(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_converter_digit_adj.sv
// Combinational shift-and-add-3 digit correction: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock.
// Build with BIN2BCD_CLAMP_EN to saturate out-of-range operands to all-9s with o_overflow.
module bin2bcd_converter
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_ready,
    output logic                  o_done_tick,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    t_bcd_state       state, state_nxt;
    logic [BIN_W-1:0] shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             load;
    logic             iter;
    logic             clamp_hit;
    logic             carry_unused;

`ifdef BIN2BCD_CLAMP_EN
    localparam logic [63:0] MAX_VAL = bcd_max(DIGITS);
    logic ovf_q;

    assign clamp_hit  = (64'(i_bin) > MAX_VAL);
    assign o_overflow = ovf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= clamp_hit;
        end
    end
`else
    assign clamp_hit  = 1'b0;
    assign o_overflow = 1'b0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit    (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Decade carry out of the top digit is dropped: result wraps modulo 10^DIGITS.
    assign carry_unused = bcd_adj[BCD_W-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= e_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        iter        = 1'b0;
        o_ready     = 1'b0;
        o_done_tick = 1'b0;
        case (state)
            e_idle: begin
                o_ready = 1'b1;
                if (i_start) begin
                    load      = 1'b1;
                    state_nxt = clamp_hit ? e_done : e_op;
                end
            end
            e_op: begin
                iter = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = e_done;
                end
            end
            e_done: begin
                o_done_tick = 1'b1;
                state_nxt   = e_idle;
            end
            default: state_nxt = e_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= i_bin;
            bcd_q   <= clamp_hit ? {DIGITS{4'h9}} : '0;
            cnt_q   <= CNT_W'(BIN_W);
        end else if (iter) begin
            shift_q <= shift_q << 1;
            bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    assign o_bcd = bcd_q;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Directed and randomized checks of bin2bcd_converter against a decimal-arithmetic reference.
// Expectations follow the BIN2BCD_CLAMP_EN build option.
module tb_bin2bcd_converter;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_bin;
    logic        o_ready;
    logic        o_done_tick;
    logic [15:0] o_bcd;
    logic        o_overflow;

    int checks   = 0;
    int failures = 0;

    bin2bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_bin       (i_bin),
        .o_ready     (o_ready),
        .o_done_tick (o_done_tick),
        .o_bcd       (o_bcd),
        .o_overflow  (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

`ifdef BIN2BCD_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    // Reference: decimal digits of the operand, saturated or wrapped at 10^DIGITS.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        if (CLAMP && v > 9999) return 16'h9999;
        x = v % 10000;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one conversion from idle; optionally re-pulses i_start mid-conversion.
    task automatic run_conv(input logic [15:0] bin, input string tag, input bit repulse);
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        int          exp_lat;
        int          n;
        int          rdy_low;
        exp_ovf = CLAMP && (bin > 16'd9999);
        exp_bcd = ref_bcd(int'(bin));
        exp_lat = exp_ovf ? 1 : BIN_W + 1;
        i_bin   = bin;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_bin   = 16'($urandom);
        n       = 0;
        rdy_low = 0;
        while (!o_done_tick && n < 40) begin
            if (!o_ready) rdy_low++;
            if (repulse && n == 3) begin
                i_start = 1'b1;
                i_bin   = 16'd1234;
            end
            if (repulse && n == 5) i_start = 1'b0;
            @(posedge i_clk); #1;
            n++;
        end
        i_start = 1'b0;
        if (!o_ready) rdy_low++;
        chk({tag, ":latency"}, 32'(n + 1), 32'(exp_lat));
        chk({tag, ":ready_low"}, 32'(rdy_low), 32'(exp_lat));
        chk({tag, ":bcd"}, 32'(o_bcd), 32'(exp_bcd));
        chk({tag, ":ovf"}, 32'(o_overflow), 32'(exp_ovf));
        @(posedge i_clk); #1;
        chk({tag, ":done_single"}, 32'(o_done_tick), 32'd0);
        chk({tag, ":ready_back"}, 32'(o_ready), 32'd1);
        i_bin = 16'($urandom);
        @(posedge i_clk); #1;
        chk({tag, ":bcd_held"}, 32'(o_bcd), 32'(exp_bcd));
    endtask

    initial begin
        int dones;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_bin   = 16'h0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset:bcd", 32'(o_bcd), 32'd0);
        chk("reset:ovf", 32'(o_overflow), 32'd0);
        chk("reset:done", 32'(o_done_tick), 32'd0);
        chk("reset:ready", 32'(o_ready), 32'd1);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_conv(16'd0,     "zero",  1'b0);
        run_conv(16'd6765,  "fib20", 1'b0);
        run_conv(16'd9999,  "max",   1'b0);
        run_conv(16'd1,     "one",   1'b0);
        run_conv(16'd10946, "fib21", 1'b0);
        run_conv(16'd10000, "tenk",  1'b0);
        run_conv(16'd65535, "full",  1'b0);
        run_conv(16'd4321,  "repulse", 1'b1);

        // Reset in the middle of a conversion.
        i_bin   = 16'd9876;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("abort:ready", 32'(o_ready), 32'd1);
        chk("abort:bcd", 32'(o_bcd), 32'd0);
        chk("abort:ovf", 32'(o_overflow), 32'd0);
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            if (o_done_tick) dones++;
            @(posedge i_clk); #1;
        end
        chk("abort:no_done", 32'(dones), 32'd0);
        run_conv(16'd55, "after_abort", 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_conv((r % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom), "rand", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
